tristate_bus_frame_tx: RTL
==========================

Name: tristate_bus_frame_tx

Overview:
- Upstream control stage for the single-bit tristate output buffer.
- Accepts a parallel word through a valid/ready handshake and serialises it into a framed bit stream.
- Produces the buffer's data input (bus_data) and enable (bus_oe) on every cycle.
- Inserts bus-release guard cycles after each frame so another driver can take the shared line safely.

Parameters:
- WIDTH, 8, payload bits per frame (valid range 1..32).
- PARITY_EN, 1, 1 = append an even-parity bit after the payload; 0 = no parity bit.
- GUARD, 2, cycles with bus_oe=0 after the stop bit (valid range 0..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_data  input  WIDTH  payload word.
- in_ready  output  1  block can accept a word.
- bus_data  output  1  bit to drive; connects to the buffer data input.
- bus_oe  output  1  drive enable; connects to the buffer enable (1 = drive, 0 = high-Z).
- busy  output  1  a frame is in progress (start, data, parity, stop or guard).
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset is asynchronous and active-low: one clock, rst_n asserted low forces all state immediately.
  - state=IDLE; bus_oe=0, bus_data=0, busy=0, done=0.
  - Shift register and counters cleared.
- in_ready = (state==IDLE). Decoded combinationally from the state register, so it is 1 during and after reset.
- Accept occurs on a rising edge with in_valid && in_ready. in_data is captured into the shift register on that edge.
- States and transitions:
  - IDLE -> START on accept.
  - START: 1 cycle; bus_oe=1, bus_data=0.
  - DATA: WIDTH cycles; bus_oe=1, bus_data = payload bit, LSB first.
  - PARITY: 1 cycle, only if PARITY_EN=1; bus_oe=1, bus_data = XOR of all payload bits (even parity).
  - STOP: 1 cycle; bus_oe=1, bus_data=1.
  - TURN: GUARD cycles; bus_oe=0, bus_data=0. Skipped entirely when GUARD=0.
  - Back to IDLE.
- Output timing:
  - bus_data, bus_oe, busy and done are registered.
  - The first START cycle is the cycle immediately after the accepting edge.
- Frame length = 1 + WIDTH + PARITY_EN + 1 + GUARD cycles. busy=1 for exactly this many cycles.
- done=1 for exactly the first IDLE cycle after a frame.
  - in_ready is also 1 in that cycle, so back-to-back accept is legal there.
  - Minimum bus_oe=0 gap between consecutive frames = GUARD+1 cycles.
- Bit counter: $clog2(WIDTH+1) bits, no wrap; it is reloaded on every state entry.
- Input behaviour:
  - in_valid is ignored when in_ready=0; no queueing.
  - Changes to in_data after accept have no effect.
- Reset asserted mid-frame:
  - bus_oe drops to 0 asynchronously and the frame is abandoned.
  - No done pulse is produced.
  - After rst_n deasserts, the block is in IDLE and ready.
- bus_oe must never be 1 in IDLE or TURN. bus_data is don't-care-free: it is always 0 whenever bus_oe=0.

Decomposition:
- Shared package tristate_bus_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, TURN);
  - constants START_BIT=1'b0 and STOP_BIT=1'b1;
  - default WIDTH/GUARD values.
- One natural sub-module: tristate_bus_shifter, a WIDTH-bit load/shift-right register with a running parity accumulator. The FSM and counters stay in the top level.

Test Plan:
- Reset, then release rst_n with in_valid=0 -> bus_oe=0, bus_data=0, busy=0, done=0, in_ready=1 held for 20 cycles.
- WIDTH=8, PARITY_EN=1, GUARD=2, accept in_data=8'hA5 ->
  - bus_oe=1 for 11 cycles with bus_data sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first payload, parity 0, stop);
  - then bus_oe=0 for 2 cycles;
  - done pulses 1 cycle later; busy high for 13 cycles.
- Accept 8'h07, with in_valid held high and in_data changed to 8'hFF during the frame ->
  - payload bits are 1,1,1,0,0,0,0,0 and parity is 1;
  - the second word is accepted only in the done cycle;
  - the next START follows after exactly 3 bus_oe=0 cycles.
- PARITY_EN=0, GUARD=0, accept 8'h80 ->
  - 10 bus_oe=1 cycles: 0,0,0,0,0,0,0,0,1,1;
  - then done immediately; no bus_oe=0 cycle during the frame.
- Assert rst_n=0 mid-payload (4th data bit) ->
  - bus_oe=0 within the same cycle without a clock edge; no done;
  - after release, accept 8'h3C frames correctly.
- Random 500-word soak ->
  - scoreboard reconstructs each word from the bus_oe=1 bits;
  - parity and frame length match the formula;
  - bus_oe is never 1 outside START..STOP.

Source files
------------

// File: rtl/tristate_bus_pkg.sv
// Shared types and constants for the tristate bus frame transmitter.
package tristate_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    TURN   = 3'd5
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_GUARD     = 2;
  localparam bit DEFAULT_PARITY_EN = 1'b1;

endpackage

// File: rtl/tristate_bus_shifter.sv
// Load / shift-right payload register that also folds each shifted-out bit into an even-parity accumulator.
module tristate_bus_shifter #(
  parameter int WIDTH = tristate_bus_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             bit_out,
  output logic             parity
);

  logic [WIDTH-1:0] sreg;

  // Parity is only complete once all WIDTH bits have been shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      parity <= 1'b0;
    end else if (load) begin
      sreg   <= load_data;
      parity <= 1'b0;
    end else if (shift) begin
      sreg   <= sreg >> 1;
      parity <= parity ^ sreg[0];
    end
  end

  assign bit_out = sreg[0];

endmodule

// File: rtl/tristate_bus_frame_tx.sv
// Framed serial transmitter driving the data/enable pins of a single-bit tristate buffer:
// START, LSB-first payload, optional even parity, STOP, then GUARD cycles with the line released.
module tristate_bus_frame_tx #(
  parameter int WIDTH     = tristate_bus_pkg::DEFAULT_WIDTH,
  parameter bit PARITY_EN = tristate_bus_pkg::DEFAULT_PARITY_EN,
  parameter int GUARD     = tristate_bus_pkg::DEFAULT_GUARD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             bus_data,
  output logic             bus_oe,
  output logic             busy,
  output logic             done
);
  import tristate_bus_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  state_t        state, next_state;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    guard_cnt;
  logic          accept, shift_en, shift_bit, parity_bit;
  logic          next_oe, next_data, next_busy, next_done;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign shift_en = (next_state == DATA);

  tristate_bus_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .shift     (shift_en),
    .load_data (in_data),
    .bit_out   (shift_bit),
    .parity    (parity_bit)
  );

  // Counters reload on every state change and count down without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      guard_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        bit_cnt   <= (next_state == DATA) ? CW'(WIDTH - 1) : '0;
        guard_cnt <= (next_state == TURN) ? 4'((GUARD > 0) ? GUARD - 1 : 0) : '0;
      end else begin
        if (bit_cnt != '0)   bit_cnt   <= bit_cnt - CW'(1);
        if (guard_cnt != '0) guard_cnt <= guard_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = START;
      START:   next_state = DATA;
      DATA:    if (bit_cnt == '0) next_state = PARITY_EN ? PARITY : STOP;
      PARITY:  next_state = STOP;
      STOP:    next_state = (GUARD == 0) ? IDLE : TURN;
      TURN:    if (guard_cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they can be registered without a cycle of lag.
  always_comb begin
    next_oe   = 1'b0;
    next_data = 1'b0;
    next_busy = (next_state != IDLE);
    next_done = (state != IDLE) && (next_state == IDLE);
    case (next_state)
      START: begin
        next_oe   = 1'b1;
        next_data = START_BIT;
      end
      DATA: begin
        next_oe   = 1'b1;
        next_data = shift_bit;
      end
      PARITY: begin
        next_oe   = 1'b1;
        next_data = parity_bit;
      end
      STOP: begin
        next_oe   = 1'b1;
        next_data = STOP_BIT;
      end
      default: begin
        next_oe   = 1'b0;
        next_data = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_oe   <= 1'b0;
      bus_data <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      bus_oe   <= next_oe;
      bus_data <= next_data;
      busy     <= next_busy;
      done     <= next_done;
    end
  end

endmodule
